// File: rtl/nm_of_if.sv
// Evaluation-request bundle between the Nelder-Mead optimizer (master) and the
// objective-function server (slave). Coordinates are signed pdQp, f(x) is unsigned 3Qp.
interface nm_of_if #(
   parameter int PD = 12,
   parameter int P  = 22
) ();
   logic [4:0]        state_i;
   logic [PD+P-1:0]   d0_i;
   logic [PD+P-1:0]   d1_i;
   logic [PD+P-1:0]   d2_i;
   logic [PD+P-1:0]   t0_i;
   logic [PD+P-1:0]   t1_i;
   logic [PD+P-1:0]   t2_i;
   logic              busy;
   logic [3+P-1:0]    OF_fx_o;
   logic              eval_done;
   logic [15:0]       eval_cnt;
   logic              overrun;

   modport master (
      output state_i, d0_i, d1_i, d2_i, t0_i, t1_i, t2_i,
      input  busy, OF_fx_o, eval_done, eval_cnt, overrun
   );

   modport slave (
      input  state_i, d0_i, d1_i, d2_i, t0_i, t1_i, t2_i,
      output busy, OF_fx_o, eval_done, eval_cnt, overrun
   );
endinterface

// File: rtl/nm_of_server.sv
// Objective-function server: f(x) = sum (dk - tk)^2 using one time-shared squarer.
// Define NM_OF_SAT_EN to saturate f(x) at just under 8.0 instead of wrapping.
module nm_of_server #(
   parameter int PD = 12,
   parameter int P  = 22
) (
   input  logic     clk,
   input  logic     rst_n,
   nm_of_if.slave   bus
);

   localparam int W  = PD + P;       // coordinate width
   localparam int DW = W + 1;        // difference width
   localparam int SW = 2 * DW;       // full square width
   localparam int AW = 2 * W + 2;    // accumulator width
   localparam int OW = 3 + P;        // f(x) width

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SQ0,
      S_SQ1,
      S_SQ2,
      S_DONE
   } fsm_e;

   fsm_e                 fsm_q, fsm_d;
   logic [4:0]           state_q;
   logic signed [DW-1:0] diff0_q, diff1_q, diff2_q;
   logic signed [DW-1:0] diff0_d, diff1_d, diff2_d;
   logic [AW-1:0]        acc_q, acc_nxt;
   logic [OW-1:0]        of_fx_q, of_fx_d;
   logic [15:0]          eval_cnt_q;
   logic                 overrun_q;

   logic                 trigger, start;
   logic                 eval_done;
   logic                 busy;
   logic                 acc_en;
   logic signed [DW-1:0] sq_in;
   logic signed [SW-1:0] sq_full;
   logic [AW-1:0]        sq_term;

   function automatic logic is_eval_code(input logic [4:0] code);
      case (code)
         5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b00000, 5'b00010,
         5'b01000, 5'b01001, 5'b10110, 5'b10111, 5'b11000: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

   // Differences are formed straight from the ports so d/t are sampled on the start edge.
   always_comb begin
      diff0_d = {bus.d0_i[W-1], bus.d0_i} - {bus.t0_i[W-1], bus.t0_i};
      diff1_d = {bus.d1_i[W-1], bus.d1_i} - {bus.t1_i[W-1], bus.t1_i};
      diff2_d = {bus.d2_i[W-1], bus.d2_i} - {bus.t2_i[W-1], bus.t2_i};
   end

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      fsm_d     = fsm_q;
      trigger   = (bus.state_i != state_q) && is_eval_code(bus.state_i);
      start     = trigger && (fsm_q == S_IDLE);
      eval_done = 1'b0;
      acc_en    = 1'b0;
      sq_in     = diff0_q;
      case (fsm_q)
         S_IDLE: if (start) fsm_d = S_LOAD;
         S_LOAD: fsm_d = S_SQ0;
         S_SQ0: begin
            sq_in  = diff0_q;
            acc_en = 1'b1;
            fsm_d  = S_SQ1;
         end
         S_SQ1: begin
            sq_in  = diff1_q;
            acc_en = 1'b1;
            fsm_d  = S_SQ2;
         end
         S_SQ2: begin
            sq_in  = diff2_q;
            acc_en = 1'b1;
            fsm_d  = S_DONE;
         end
         S_DONE: begin
            eval_done = 1'b1;
            fsm_d     = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
      busy = rst_n && (start || (fsm_q inside {S_LOAD, S_SQ0, S_SQ1, S_SQ2}));
   end

   // The square of a signed value is non-negative, so the shift may treat it as unsigned.
   always_comb begin
      sq_full = sq_in * sq_in;
      sq_term = $unsigned(sq_full) >> P;
      acc_nxt = acc_q + sq_term;
   end

`ifdef NM_OF_SAT_EN
   always_comb begin
      if (|acc_nxt[AW-1:OW]) of_fx_d = '1;
      else                   of_fx_d = acc_nxt[OW-1:0];
   end
`else
   always_comb begin
      of_fx_d = acc_nxt[OW-1:0];
   end
`endif

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= S_IDLE;
         state_q <= 5'b11111;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= bus.state_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff0_q    <= '0;
         diff1_q    <= '0;
         diff2_q    <= '0;
         acc_q      <= '0;
         of_fx_q    <= '0;
         eval_cnt_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         if (start) begin
            diff0_q <= diff0_d;
            diff1_q <= diff1_d;
            diff2_q <= diff2_d;
            acc_q   <= '0;
         end else if (acc_en) begin
            acc_q <= acc_nxt;
         end
         // The result lands on the edge that enters DONE, so it is valid with eval_done.
         if (fsm_q == S_SQ2) begin
            of_fx_q    <= of_fx_d;
            eval_cnt_q <= eval_cnt_q + 16'd1;
         end
         if (trigger && (fsm_q != S_IDLE)) overrun_q <= 1'b1;
      end
   end

   assign bus.busy      = busy;
   assign bus.OF_fx_o   = of_fx_q;
   assign bus.eval_done = eval_done;
   assign bus.eval_cnt  = eval_cnt_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_nm_of_server.sv
// Directed plus randomized bench for nm_of_server; f(x) is predicted from the
// arithmetic definition sum floor((dk-tk)^2 / 2^p), wrapped or saturated at 8.0.
module tb_nm_of_server;

   localparam int PD = 12;
   localparam int P  = 22;
   localparam int W  = PD + P;
   localparam int OW = 3 + P;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_err;
   logic [15:0] exp_cnt;

   nm_of_if #(.PD(PD), .P(P)) bus ();

   nm_of_server #(.PD(PD), .P(P)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OW-1:0] model_f(input logic [2:0][W-1:0] d, input logic [2:0][W-1:0] t);
      logic [127:0] sum;
      sum = '0;
      for (int k = 0; k < 3; k++) begin
         longint dv, tv;
         logic signed [127:0] df;
         dv = longint'($signed(d[k]));
         tv = longint'($signed(t[k]));
         df = 128'(dv - tv);
         sum = sum + ((df * df) >> P);
      end
`ifdef NM_OF_SAT_EN
      if (sum >= (128'd1 << OW)) return '1;
`endif
      return sum[OW-1:0];
   endfunction

   function automatic logic [W-1:0] rand_coord();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 2))
         0:       return r[W-1:0];
         1:       return W'($signed(r[26:0]));
         default: return W'($signed(r[23:0]));
      endcase
   endfunction

   task automatic drive_point(input logic [2:0][W-1:0] d, input logic [2:0][W-1:0] t);
      bus.d0_i = d[0]; bus.d1_i = d[1]; bus.d2_i = d[2];
      bus.t0_i = t[0]; bus.t1_i = t[1]; bus.t2_i = t[2];
   endtask

   // Starts at posedge+2 of some cycle; ends at posedge+2 of the cycle after DONE.
   task automatic run_eval(input logic [4:0] code, input logic [2:0][W-1:0] d,
                           input logic [2:0][W-1:0] t, input bit scramble, input string tag);
      logic [OW-1:0] exp_f;
      logic [2:0][W-1:0] junk;
      exp_f = model_f(d, t);
      bus.state_i = 5'b11111;
      @(posedge clk); #1;
      drive_point(d, t);
      bus.state_i = code;
      #1;
      check({tag, "/busy_c0"}, 64'(bus.busy), 64'd1);
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         if (scramble && c == 2) begin
            for (int k = 0; k < 3; k++) junk[k] = rand_coord();
            drive_point(junk, junk);
         end
         #1;
         check({tag, "/busy_mid"}, 64'(bus.busy), 64'd1);
         check({tag, "/done_mid"}, 64'(bus.eval_done), 64'd0);
      end
      @(posedge clk); #2;
      exp_cnt = exp_cnt + 16'd1;
      check({tag, "/busy_c5"}, 64'(bus.busy), 64'd0);
      check({tag, "/done_c5"}, 64'(bus.eval_done), 64'd1);
      check({tag, "/fx"}, 64'(bus.OF_fx_o), 64'(exp_f));
      check({tag, "/cnt"}, 64'(bus.eval_cnt), 64'(exp_cnt));
      @(posedge clk); #2;
      check({tag, "/done_c6"}, 64'(bus.eval_done), 64'd0);
      check({tag, "/busy_c6"}, 64'(bus.busy), 64'd0);
      check({tag, "/fx_hold"}, 64'(bus.OF_fx_o), 64'(exp_f));
   endtask

   initial begin
      logic [4:0] eval_codes [11];
      logic [2:0][W-1:0] d, t;
      logic [OW-1:0] exp_f;
      int done_seen;

      eval_codes = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b00000, 5'b00010,
                     5'b01000, 5'b01001, 5'b10110, 5'b10111, 5'b11000};
      n_checks = 0;
      n_err    = 0;
      exp_cnt  = '0;
      rst_n    = 1'b0;
      bus.state_i = 5'b11111;
      d = '0;
      t = '0;
      drive_point(d, t);

      // Reset state
      #2;
      check("rst/busy", 64'(bus.busy), 64'd0);
      check("rst/fx", 64'(bus.OF_fx_o), 64'd0);
      check("rst/done", 64'(bus.eval_done), 64'd0);
      check("rst/cnt", 64'(bus.eval_cnt), 64'd0);
      check("rst/overrun", 64'(bus.overrun), 64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #2;

      // Basic evaluation: 1^2 + 2^2 = 5.0
      d = '{W'(0), W'(34'h800000), W'(34'h400000)};
      t = '0;
      run_eval(5'b10000, d, t, 1'b0, "basic");
      check("basic/fx_abs", 64'(bus.OF_fx_o), 64'h1400000);

      // Signed difference: -0.5 - 0.5 = -1.0, squared 1.0
      d = '{W'(34'h123456), W'(34'h3_FFC0_0000), -W'(34'h200000)};
      t = '{W'(34'h123456), W'(34'h3_FFC0_0000), W'(34'h200000)};
      run_eval(5'b00010, d, t, 1'b0, "signed");
      check("signed/fx_abs", 64'(bus.OF_fx_o), 64'h400000);

      // Overflow: 3.0^2 = 9.0
      d = '{W'(0), W'(0), W'(34'hC00000)};
      t = '0;
      run_eval(5'b11000, d, t, 1'b0, "ovf");
`ifdef NM_OF_SAT_EN
      check("ovf/fx_abs", 64'(bus.OF_fx_o), 64'h1FFFFFF);
`else
      check("ovf/fx_abs", 64'(bus.OF_fx_o), 64'h400000);
`endif

      // Randomized points over all eval codes, inputs disturbed after the sampling edge
      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < 3; k++) begin
            d[k] = rand_coord();
            t[k] = rand_coord();
         end
         run_eval(eval_codes[$urandom_range(0, 10)], d, t, (i % 2) == 1, "rand");
      end

      // Non-eval codes never raise busy
      bus.state_i = 5'b10100;
      for (int c = 0; c < 6; c++) begin
         #1 check("noneval/busy", 64'(bus.busy), 64'd0);
         @(posedge clk); #1;
         if (c == 2) bus.state_i = 5'b10101;
      end
      check("noneval/cnt", 64'(bus.eval_cnt), 64'(exp_cnt));

      // Held eval state: exactly one evaluation in 20 cycles
      d = '{W'(34'h3_FFF0_0000), W'(34'h100000), W'(34'h280000)};
      t = '{W'(0), W'(34'h3_FFE0_0000), W'(34'h80000)};
      exp_f = model_f(d, t);
      drive_point(d, t);
      bus.state_i = 5'b00000;
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus.eval_done === 1'b1) done_seen++;
         @(posedge clk); #1;
      end
      exp_cnt = exp_cnt + 16'd1;
      check("hold/pulses", 64'(done_seen), 64'd1);
      check("hold/cnt", 64'(bus.eval_cnt), 64'(exp_cnt));
      check("hold/fx", 64'(bus.OF_fx_o), 64'(exp_f));
      check("hold/overrun", 64'(bus.overrun), 64'd0);

      // Overrun: 00000 -> 00010 in cycle 2; result reflects the 00000 point
      bus.state_i = 5'b11111;
      @(posedge clk); #1;
      d = '{W'(34'h40000), W'(34'h3_FF80_0000), W'(34'h600000)};
      t = '0;
      exp_f = model_f(d, t);
      drive_point(d, t);
      bus.state_i = 5'b00000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.state_i = 5'b00010;
      drive_point(t, d);
      #1 check("ovr/busy_c2", 64'(bus.busy), 64'd1);
      @(posedge clk); #2;
      check("ovr/flag", 64'(bus.overrun), 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #2;
      exp_cnt = exp_cnt + 16'd1;
      check("ovr/done", 64'(bus.eval_done), 64'd1);
      check("ovr/fx", 64'(bus.OF_fx_o), 64'(exp_f));
      check("ovr/cnt", 64'(bus.eval_cnt), 64'(exp_cnt));
      @(posedge clk); #2;
      check("ovr/no_retrig", 64'(bus.busy), 64'd0);
      check("ovr/sticky", 64'(bus.overrun), 64'd1);

      // Reset in cycle 3 of an evaluation aborts it and clears everything
      bus.state_i = 5'b11111;
      @(posedge clk); #1;
      d = '{W'(34'h100000), W'(34'h100000), W'(34'h100000)};
      drive_point(d, t);
      bus.state_i = 5'b10110;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      check("abort/busy", 64'(bus.busy), 64'd0);
      check("abort/fx", 64'(bus.OF_fx_o), 64'd0);
      check("abort/done", 64'(bus.eval_done), 64'd0);
      check("abort/cnt", 64'(bus.eval_cnt), 64'd0);
      check("abort/overrun", 64'(bus.overrun), 64'd0);
      bus.state_i = 5'b11111;
      @(posedge clk); #3 rst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #2;
         if (bus.eval_done === 1'b1) done_seen++;
      end
      check("abort/no_done", 64'(done_seen), 64'd0);
      check("abort/cnt_after", 64'(bus.eval_cnt), 64'd0);

      // A trigger landing in the DONE cycle is an overrun and is not queued
      d = '{W'(34'h200000), W'(0), W'(34'h3_FFA0_0000)};
      t = '{W'(0), W'(34'h80000), W'(0)};
      run_eval(5'b01000, d, t, 1'b0, "post");
      check("post/no_overrun", 64'(bus.overrun), 64'd0);
      bus.state_i = 5'b11111;
      @(posedge clk); #1;
      bus.state_i = 5'b01001;
      repeat (5) @(posedge clk);
      #1 bus.state_i = 5'b10001;
      #1;
      exp_cnt = exp_cnt + 16'd1;
      check("late/done", 64'(bus.eval_done), 64'd1);
      check("late/cnt", 64'(bus.eval_cnt), 64'(exp_cnt));
      @(posedge clk); #2;
      check("late/overrun", 64'(bus.overrun), 64'd1);
      check("late/no_start", 64'(bus.busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
